// File: rtl/transport_receive.sv
// transport_receive: splits fixed-length link-layer byte packets into control words and buffered audio samples.
// Latency: ctrl_valid_o and err_*_o pulse 1 cycle after the deciding byte; a sample is pushed 1 cycle after its lo byte.
// Backpressure: none toward the link layer; a sample pushed into a full, unpopped FIFO is dropped and audio_overflow_o sticks.
// Ports: clk, reset (synchronous, active-high)
//   rx_active_i / rx_valid_i / rx_byte_i         : packet envelope, byte strobe and byte from the link layer
//   ctrl_valid_o / ctrl_data_o                   : control word strobe and held value
//   audio_valid_o / audio_data_o / audio_rd_i    : show-ahead sample FIFO head and pop
//   audio_overflow_o, err_header_o, err_trailer_o, err_truncated_o, busy_o : status

// Sample FIFO: show-ahead head, simultaneous push/pop allowed even when full.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: a push into a full FIFO is lost unless a pop happens in the same cycle; a pop of an empty FIFO is ignored.
// Ports: push_i/push_dat_i write side, pop_i/head_dat_o read side, empty_o/full_o occupancy flags.
module transport_receive_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16   // power of 2, >= 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_pop, do_push;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  // When full, a same-cycle pop frees the slot the push lands in (wr_ptr == rd_ptr).
  assign do_push = push_i && (!full_o || do_pop);
  // Head is forced to zero while empty so the output never shows stale or uninitialised storage.
  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

module transport_receive #(
  parameter int PACKET_SIZE = 16,  // even, >= 4
  parameter int AUDIO_DEPTH = 16   // power of 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_active_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_byte_i,
  output logic        ctrl_valid_o,
  output logic [15:0] ctrl_data_o,
  output logic        audio_valid_o,
  output logic [15:0] audio_data_o,
  input  logic        audio_rd_i,
  output logic        audio_overflow_o,
  output logic        err_header_o,
  output logic        err_trailer_o,
  output logic        err_truncated_o,
  output logic        busy_o
);
  localparam int BW = $clog2(PACKET_SIZE + 1);
  localparam logic [BW-1:0] BCNT_ONE   = BW'(1);
  localparam logic [BW-1:0] BCNT_LAST  = BW'(PACKET_SIZE);
  localparam logic [BW-1:0] BCNT_TRAIL = BW'(PACKET_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CTRL_HI, S_CTRL_LO, S_PAD, S_AUD_HI, S_AUD_LO, S_TRAIL, S_DRAIN
  } state_t;

  state_t        state_q;
  logic [BW-1:0] bcnt_q;
  logic [15:0]   ctrl_hold_q;
  logic [15:0]   ctrl_data_q;
  logic          ctrl_valid_q;
  logic [7:0]    samp_hi_q;
  logic          push_q;
  logic [15:0]   push_dat_q;
  logic          overflow_q;
  logic          err_header_q, err_trailer_q, err_truncated_q;

  logic          byte_acc;
  logic [BW-1:0] bcnt_inc;
  logic          fifo_empty, fifo_full;
  logic [15:0]   fifo_head;

  assign byte_acc = rx_valid_i && rx_active_i;
  assign bcnt_inc = bcnt_q + BCNT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      bcnt_q          <= '0;
      ctrl_hold_q     <= '0;
      ctrl_data_q     <= '0;
      ctrl_valid_q    <= 1'b0;
      samp_hi_q       <= '0;
      push_q          <= 1'b0;
      push_dat_q      <= '0;
      overflow_q      <= 1'b0;
      err_header_q    <= 1'b0;
      err_trailer_q   <= 1'b0;
      err_truncated_q <= 1'b0;
    end else begin
      ctrl_valid_q    <= 1'b0;
      push_q          <= 1'b0;
      err_header_q    <= 1'b0;
      err_trailer_q   <= 1'b0;
      err_truncated_q <= 1'b0;

      // Full FIFO is never empty, so any asserted read is a real pop that makes room.
      if (push_q && fifo_full && !audio_rd_i) overflow_q <= 1'b1;

      if (!rx_active_i && state_q != S_IDLE && state_q != S_DRAIN) begin
        // Envelope dropped mid-packet: abandon it; already pushed samples stay.
        err_truncated_q <= 1'b1;
        state_q         <= S_IDLE;
        bcnt_q          <= '0;
      end else if (!rx_active_i && state_q == S_DRAIN) begin
        state_q <= S_IDLE;
        bcnt_q  <= '0;
      end else if (byte_acc) begin
        bcnt_q <= bcnt_inc;
        case (state_q)
          S_IDLE: begin
            bcnt_q <= BCNT_ONE;
            if (rx_byte_i == 8'h40) begin
              state_q <= S_CTRL_HI;
            end else if (rx_byte_i == 8'h80) begin
              state_q <= S_AUD_HI;
            end else begin
              err_header_q <= 1'b1;
              state_q      <= S_DRAIN;
            end
          end
          S_CTRL_HI: begin
            ctrl_hold_q[15:8] <= rx_byte_i;
            state_q           <= S_CTRL_LO;
          end
          S_CTRL_LO: begin
            ctrl_hold_q[7:0] <= rx_byte_i;
            state_q          <= S_PAD;
          end
          S_PAD: begin
            // Word is only released once the whole packet has arrived.
            if (bcnt_inc == BCNT_LAST) begin
              ctrl_data_q  <= ctrl_hold_q;
              ctrl_valid_q <= 1'b1;
              state_q      <= S_IDLE;
            end
          end
          S_AUD_HI: begin
            samp_hi_q <= rx_byte_i;
            state_q   <= S_AUD_LO;
          end
          S_AUD_LO: begin
            push_q     <= 1'b1;
            push_dat_q <= {samp_hi_q, rx_byte_i};
            state_q    <= (bcnt_inc == BCNT_TRAIL) ? S_TRAIL : S_AUD_HI;
          end
          S_TRAIL: begin
            if (rx_byte_i != 8'hFF) err_trailer_q <= 1'b1;
            state_q <= S_IDLE;
          end
          S_DRAIN: begin
            if (bcnt_inc == BCNT_LAST) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  transport_receive_fifo #(
    .WIDTH(16),
    .DEPTH(AUDIO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push_q),
    .push_dat_i(push_dat_q),
    .pop_i     (audio_rd_i),
    .head_dat_o(fifo_head),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign ctrl_valid_o     = ctrl_valid_q;
  assign ctrl_data_o      = ctrl_data_q;
  assign audio_valid_o    = !fifo_empty;
  assign audio_data_o     = fifo_head;
  assign audio_overflow_o = overflow_q;
  assign err_header_o     = err_header_q;
  assign err_trailer_o    = err_trailer_q;
  assign err_truncated_o  = err_truncated_q;
  assign busy_o           = (state_q != S_IDLE);
endmodule
